// File: rtl/sd_sector_responder_pkg.sv
// Shared definitions for the sector responder: FSM state encoding, sector
// geometry constants and a small helper used to size drive-index fields.
package sd_resp_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_STB  = 3'd2,
        WR_ADDR = 3'd3,
        WR_CAP  = 3'd4,
        WR_REQ  = 3'd5,
        DONE    = 3'd6
    } sd_resp_state_t;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_SHIFT = 9;
    localparam logic [SECTOR_SHIFT-1:0] LAST_IDX = SECTOR_SHIFT'(SECTOR_BYTES - 1);

    // Width of a drive index; a single-drive build still needs one bit.
    function automatic int drive_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_sector_responder_if.sv
// Bus bundles around the sector responder.
//   sd_sector_if : core-side sector-buffer handshake. master = core (tatung),
//                  slave = responder.
//     sd_lba, sd_rd, sd_wr, sd_buff_din, img_size  : core -> responder
//     sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr: responder -> core
//   sd_mem_if    : byte-wide request/ready image memory port. master =
//                  responder, slave = memory.
//     mem_addr, mem_rd, mem_wr, mem_wdata : responder -> memory
//     mem_rdata, mem_ready                : memory -> responder
interface sd_sector_if #(
    parameter int NDRIVES = 2
);
    logic [31:0]            sd_lba;
    logic [NDRIVES-1:0]     sd_rd;
    logic [NDRIVES-1:0]     sd_wr;
    logic                   sd_ack;
    logic [8:0]             sd_buff_addr;
    logic [7:0]             sd_buff_dout;
    logic                   sd_buff_wr;
    logic [7:0]             sd_buff_din;
    logic [NDRIVES*32-1:0]  img_size;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, img_size,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, img_size,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
endinterface

interface sd_mem_if #(
    parameter int MEM_AW = 24
);
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/sd_sector_responder_arbiter.sv
// Combinational request arbiter for the sector responder.
// Picks the lowest-numbered drive with a read or write request pending; on
// that drive a read wins over a write.
//   rd_i, wr_i  : per-drive level request bits
//   valid_o     : at least one request pending
//   drive_o     : selected drive index
//   is_write_o  : selected request is a write
module sd_resp_arbiter
    import sd_resp_pkg::*;
#(
    parameter int NDRIVES = 2
) (
    input  logic [NDRIVES-1:0]               rd_i,
    input  logic [NDRIVES-1:0]               wr_i,
    output logic                             valid_o,
    output logic [drive_bits(NDRIVES)-1:0]   drive_o,
    output logic                             is_write_o
);
    localparam int DRV_W = drive_bits(NDRIVES);

    logic [NDRIVES-1:0] req;

    generate
        for (genvar gi = 0; gi < NDRIVES; gi++) begin : g_req
            assign req[gi] = rd_i[gi] | wr_i[gi];
        end
    endgenerate

    assign valid_o = |req;

    // Scan upward and keep only the first hit so drive 0 has top priority.
    always_comb begin
        logic found;
        found      = 1'b0;
        drive_o    = '0;
        is_write_o = 1'b0;
        for (int i = 0; i < NDRIVES; i++) begin
            if (!found && req[i]) begin
                found      = 1'b1;
                drive_o    = DRV_W'(i);
                is_write_o = ~rd_i[i];
            end
        end
    end

endmodule

// File: rtl/sd_sector_responder.sv
// Sector responder: serves the core's per-drive sector read/write requests
// from a byte-wide image memory. On accept it raises sd_ack, then moves 512
// bytes between the core's sector buffer and memory, one memory access per
// byte, and drops sd_ack when the sector is complete.
//   clk_sys, reset : clock and asynchronous active-high reset
//   sec (slave)    : sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*/img_size
//   mem (master)   : mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata/mem_ready
//   busy           : high whenever the FSM is not IDLE
module sd_sector_responder
    import sd_resp_pkg::*;
#(
    parameter int NDRIVES     = 2,
    parameter int MEM_AW      = 24,
    parameter int DRIVE_SHIFT = 20
) (
    input  logic      clk_sys,
    input  logic      reset,
    sd_sector_if.slave sec,
    sd_mem_if.master   mem,
    output logic      busy
);
    localparam int DRV_W   = drive_bits(NDRIVES);
    localparam int BYTE_AW = 32 + SECTOR_SHIFT;

    sd_resp_state_t          state_q;
    logic [DRV_W-1:0]        drive_q;
    logic [31:0]             lba_q;
    logic                    oob_q;
    logic [SECTOR_SHIFT-1:0] idx_q;
    logic                    sd_ack_q;
    logic [8:0]              sd_buff_addr_q;
    logic [7:0]              sd_buff_dout_q;
    logic                    sd_buff_wr_q;
    logic [MEM_AW-1:0]       mem_addr_q;
    logic                    mem_rd_q;
    logic                    mem_wr_q;
    logic [7:0]              mem_wdata_q;

    logic                    arb_valid;
    logic [DRV_W-1:0]        arb_drive;
    logic                    arb_is_write;
    logic [31:0]             img_sel;
    logic                    oob_d;
    logic [SECTOR_SHIFT-1:0] idx_inc;

    sd_resp_arbiter #(
        .NDRIVES (NDRIVES)
    ) u_arbiter (
        .rd_i       (sec.sd_rd),
        .wr_i       (sec.sd_wr),
        .valid_o    (arb_valid),
        .drive_o    (arb_drive),
        .is_write_o (arb_is_write)
    );

    // Byte offset of the requested sector versus the mounted image size;
    // an unmounted drive (size 0) is always out of range.
    assign img_sel = sec.img_size[32*int'(arb_drive) +: 32];
    assign oob_d   = ({sec.sd_lba, {SECTOR_SHIFT{1'b0}}} >= {{SECTOR_SHIFT{1'b0}}, img_sel});
    assign idx_inc = idx_q + 1'b1;

    // Each drive owns a 2**DRIVE_SHIFT byte window; the sum simply wraps at
    // MEM_AW bits.
    function automatic logic [MEM_AW-1:0] calc_addr(
        input logic [DRV_W-1:0]        drv,
        input logic [31:0]             lba,
        input logic [SECTOR_SHIFT-1:0] idx
    );
        logic [BYTE_AW-1:0] base;
        base = BYTE_AW'(drv) << DRIVE_SHIFT;
        return MEM_AW'(base + {lba, idx});
    endfunction

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            drive_q        <= '0;
            lba_q          <= '0;
            oob_q          <= 1'b0;
            idx_q          <= '0;
            sd_ack_q       <= 1'b0;
            sd_buff_addr_q <= '0;
            sd_buff_dout_q <= '0;
            sd_buff_wr_q   <= 1'b0;
            mem_addr_q     <= '0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_wdata_q    <= '0;
        end else begin
            sd_buff_wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        drive_q        <= arb_drive;
                        lba_q          <= sec.sd_lba;
                        oob_q          <= oob_d;
                        idx_q          <= '0;
                        sd_ack_q       <= 1'b1;
                        sd_buff_addr_q <= '0;
                        mem_addr_q     <= calc_addr(arb_drive, sec.sd_lba, '0);
                        if (arb_is_write) begin
                            state_q <= WR_ADDR;
                        end else begin
                            // First read request goes out together with sd_ack.
                            mem_rd_q <= ~oob_d;
                            state_q  <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (oob_q) begin
                        sd_buff_dout_q <= 8'hFF;
                        sd_buff_addr_q <= idx_q;
                        sd_buff_wr_q   <= 1'b1;
                        state_q        <= RD_STB;
                    end else if (mem.mem_ready) begin
                        mem_rd_q       <= 1'b0;
                        sd_buff_dout_q <= mem.mem_rdata;
                        sd_buff_addr_q <= idx_q;
                        sd_buff_wr_q   <= 1'b1;
                        state_q        <= RD_STB;
                    end
                end
                RD_STB: begin
                    if (idx_q == LAST_IDX) begin
                        sd_ack_q <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        idx_q      <= idx_inc;
                        mem_addr_q <= calc_addr(drive_q, lba_q, idx_inc);
                        mem_rd_q   <= ~oob_q;
                        state_q    <= RD_REQ;
                    end
                end
                WR_ADDR: begin
                    // sd_buff_addr already holds idx; the core's buffer RAM
                    // returns the byte one cycle later.
                    state_q <= WR_CAP;
                end
                WR_CAP: begin
                    mem_wdata_q <= sec.sd_buff_din;
                    mem_addr_q  <= calc_addr(drive_q, lba_q, idx_q);
                    mem_wr_q    <= ~oob_q;
                    state_q     <= WR_REQ;
                end
                WR_REQ: begin
                    if (oob_q || mem.mem_ready) begin
                        mem_wr_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            sd_ack_q <= 1'b0;
                            state_q  <= DONE;
                        end else begin
                            idx_q          <= idx_inc;
                            sd_buff_addr_q <= idx_inc;
                            state_q        <= WR_ADDR;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sec.sd_ack       = sd_ack_q;
    assign sec.sd_buff_addr = sd_buff_addr_q;
    assign sec.sd_buff_dout = sd_buff_dout_q;
    assign sec.sd_buff_wr   = sd_buff_wr_q;
    assign mem.mem_addr     = mem_addr_q;
    assign mem.mem_rd       = mem_rd_q;
    assign mem.mem_wr       = mem_wr_q;
    assign mem.mem_wdata    = mem_wdata_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_sd_sector_responder.sv
// Directed bench for sd_sector_responder: a table of whole-sector transfers
// plus hand-written priority and reset-abort sequences. A small memory model
// answers mem_rd with addr[7:0] after a programmable stall; the core buffer
// model holds ~idx with a one-cycle registered read.
module tb_sd_sector_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    sd_sector_if #(.NDRIVES(2)) sec_if ();
    sd_mem_if    #(.MEM_AW(24)) mem_if ();

    sd_sector_responder #(
        .NDRIVES     (2),
        .MEM_AW      (24),
        .DRIVE_SHIFT (20)
    ) dut (
        .clk_sys (clk),
        .reset   (rst),
        .sec     (sec_if.slave),
        .mem     (mem_if.master),
        .busy    (busy)
    );

    // ---------------- memory and core-buffer models ----------------
    int        stall = 0;
    int        wait_cnt = 0;
    logic [7:0] core_buf [512];
    logic [7:0] buf_rd_q = 8'h00;

    assign mem_if.mem_ready  = (mem_if.mem_rd | mem_if.mem_wr) && (wait_cnt == stall);
    assign mem_if.mem_rdata  = mem_if.mem_addr[7:0];
    assign sec_if.sd_buff_din = buf_rd_q;

    always @(posedge clk) begin
        if ((mem_if.mem_rd | mem_if.mem_wr) && !mem_if.mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        buf_rd_q <= core_buf[sec_if.sd_buff_addr];
    end

    // ---------------- monitor (samples on the falling edge) ----------------
    logic        mon_clear = 1'b0;
    logic [23:0] exp_rd_base = '0;
    logic [23:0] exp_wr_base = '0;
    logic        exp_oob = 1'b0;
    int ack_cyc, strobe_n, rd_n, wr_n, rd_cyc, strobe_err, data_err, addr_err;

    always @(negedge clk) begin
        if (mon_clear) begin
            ack_cyc <= 0; strobe_n <= 0; rd_n <= 0; wr_n <= 0; rd_cyc <= 0;
            strobe_err <= 0; data_err <= 0; addr_err <= 0;
        end else begin
            if (sec_if.sd_ack) ack_cyc <= ack_cyc + 1;
            if (mem_if.mem_rd) rd_cyc <= rd_cyc + 1;
            if (mem_if.mem_rd && mem_if.mem_wr) addr_err <= addr_err + 1;
            if (sec_if.sd_buff_wr) begin
                if (sec_if.sd_buff_addr != 9'(strobe_n)) strobe_err <= strobe_err + 1;
                if (sec_if.sd_buff_dout != (exp_oob ? 8'hFF : 8'(32'(exp_rd_base) + strobe_n)))
                    data_err <= data_err + 1;
                strobe_n <= strobe_n + 1;
            end
            if (mem_if.mem_rd && mem_if.mem_ready) begin
                if (mem_if.mem_addr != 24'(32'(exp_rd_base) + rd_n)) addr_err <= addr_err + 1;
                rd_n <= rd_n + 1;
            end
            if (mem_if.mem_wr && mem_if.mem_ready) begin
                if (mem_if.mem_addr != 24'(32'(exp_wr_base) + wr_n)) addr_err <= addr_err + 1;
                if (mem_if.mem_wdata != 8'(~wr_n)) data_err <= data_err + 1;
                wr_n <= wr_n + 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic clear_mon();
        mon_clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mon_clear = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [31:0] lba;
        logic [31:0] img0;
        logic [31:0] img1;
        int          stall;
        logic        oob;
        logic [23:0] rd_base;
        logic [23:0] wr_base;
        int          ack;
        int          strobes;
        int          rd_n;
        int          wr_n;
        int          rd_cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input int n, input vec_t v);
        bit ok;
        sec_if.img_size = {v.img1, v.img0};
        stall       = v.stall;
        exp_rd_base = v.rd_base;
        exp_wr_base = v.wr_base;
        exp_oob     = v.oob;
        clear_mon();
        sec_if.sd_lba = v.lba;
        sec_if.sd_rd  = v.rd;
        sec_if.sd_wr  = v.wr;
        @(negedge clk);
        check($sformatf("v%0d_ack_rise", n), sec_if.sd_ack, 1);
        sec_if.sd_rd  = 2'b00;
        sec_if.sd_wr  = 2'b00;
        sec_if.sd_lba = 32'hDEAD_BEEF;
        wait_idle(8000, ok);
        check($sformatf("v%0d_idle_reached", n), ok, 1);
        check($sformatf("v%0d_ack_cycles", n), ack_cyc, v.ack);
        check($sformatf("v%0d_strobes", n), strobe_n, v.strobes);
        check($sformatf("v%0d_mem_reads", n), rd_n, v.rd_n);
        check($sformatf("v%0d_mem_writes", n), wr_n, v.wr_n);
        check($sformatf("v%0d_mem_rd_cycles", n), rd_cyc, v.rd_cyc);
        check($sformatf("v%0d_strobe_addr_err", n), strobe_err, 0);
        check($sformatf("v%0d_data_err", n), data_err, 0);
        check($sformatf("v%0d_addr_err", n), addr_err, 0);
        check($sformatf("v%0d_buff_addr_hold", n), sec_if.sd_buff_addr, 511);
        check($sformatf("v%0d_ack_low", n), sec_if.sd_ack, 0);
        $display("xfer %0d: rd=%b wr=%b lba=%0d stall=%0d ack_cycles=%0d strobes=%0d mem_rd=%0d mem_wr=%0d",
                 n, v.rd, v.wr, v.lba, v.stall, ack_cyc, strobe_n, rd_n, wr_n);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit ok;
        for (int i = 0; i < 512; i++) core_buf[i] = 8'(~i);
        sec_if.sd_lba   = '0;
        sec_if.sd_rd    = '0;
        sec_if.sd_wr    = '0;
        sec_if.img_size = {32'd737280, 32'd737280};

        // Field order: rd, wr, lba, img0, img1, stall, oob, rd_base, wr_base,
        //              ack cycles, strobes, mem reads, mem writes, mem_rd cycles
        vecs[0] = '{2'b01, 2'b00, 32'd3,    32'd737280, 32'd737280, 0, 1'b0, 24'h000600, 24'h000000, 1024, 512, 512,   0,  512};
        vecs[1] = '{2'b00, 2'b10, 32'd0,    32'd737280, 32'd737280, 0, 1'b0, 24'h000000, 24'h100000, 1536,   0,   0, 512,    0};
        vecs[2] = '{2'b10, 2'b00, 32'd0,    32'd737280, 32'd0,      0, 1'b1, 24'h000000, 24'h000000, 1024, 512,   0,   0,    0};
        vecs[3] = '{2'b01, 2'b00, 32'd3,    32'd737280, 32'd737280, 5, 1'b0, 24'h000600, 24'h000000, 3584, 512, 512,   0, 3072};
        vecs[4] = '{2'b00, 2'b10, 32'd0,    32'd737280, 32'd0,      0, 1'b1, 24'h000000, 24'h000000, 1536,   0,   0,   0,    0};
        vecs[5] = '{2'b01, 2'b00, 32'd1439, 32'd737280, 32'd737280, 0, 1'b0, 24'h0B3E00, 24'h000000, 1024, 512, 512,   0,  512};
        vecs[6] = '{2'b01, 2'b00, 32'd1440, 32'd737280, 32'd737280, 0, 1'b1, 24'h000000, 24'h000000, 1024, 512,   0,   0,    0};
        vecs[7] = '{2'b00, 2'b01, 32'd5,    32'd737280, 32'd737280, 2, 1'b0, 24'h000000, 24'h000A00, 2560,   0,   0, 512,    0};
        vecs[8] = '{2'b01, 2'b01, 32'd3,    32'd737280, 32'd737280, 0, 1'b0, 24'h000600, 24'h000000, 1024, 512, 512,   0,  512};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_sd_ack", sec_if.sd_ack, 0);
        check("rst_buff_addr", sec_if.sd_buff_addr, 0);
        check("rst_buff_dout", sec_if.sd_buff_dout, 0);
        check("rst_buff_wr", sec_if.sd_buff_wr, 0);
        check("rst_mem_addr", mem_if.mem_addr, 0);
        check("rst_mem_rd", mem_if.mem_rd, 0);
        check("rst_mem_wr", mem_if.mem_wr, 0);
        check("rst_mem_wdata", mem_if.mem_wdata, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_release", busy, 0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Priority: drive 1 read and drive 0 write together -> write first
        sec_if.img_size = {32'd737280, 32'd737280};
        stall       = 0;
        exp_rd_base = 24'h100000;
        exp_wr_base = 24'h000000;
        exp_oob     = 1'b0;
        clear_mon();
        sec_if.sd_lba = 32'd0;
        sec_if.sd_rd  = 2'b10;
        sec_if.sd_wr  = 2'b01;
        @(negedge clk);
        check("prio_ack_rise_1", sec_if.sd_ack, 1);
        sec_if.sd_wr = 2'b00;
        wait_idle(8000, ok);
        check("prio_idle_1", ok, 1);
        check("prio_first_writes", wr_n, 512);
        check("prio_first_no_reads", rd_n, 0);
        @(negedge clk);
        check("prio_ack_rise_2", sec_if.sd_ack, 1);
        sec_if.sd_rd = 2'b00;
        wait_idle(8000, ok);
        check("prio_idle_2", ok, 1);
        check("prio_second_reads", rd_n, 512);
        check("prio_second_strobes", strobe_n, 512);
        check("prio_addr_err", addr_err, 0);
        check("prio_data_err", data_err, 0);
        check("prio_ack_cycles", ack_cyc, 1536 + 1024);
        $display("xfer prio: mem_wr=%0d mem_rd=%0d strobes=%0d ack_cycles=%0d", wr_n, rd_n, strobe_n, ack_cyc);

        // Reset abort in the middle of a read
        exp_rd_base = 24'h000600;
        exp_wr_base = 24'h000000;
        clear_mon();
        sec_if.sd_lba = 32'd3;
        sec_if.sd_rd  = 2'b01;
        @(negedge clk);
        check("abort_ack_rise", sec_if.sd_ack, 1);
        sec_if.sd_rd = 2'b00;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (strobe_n >= 100 && mem_if.mem_rd) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_reached_byte100", ok, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_sd_ack", sec_if.sd_ack, 0);
        check("abort_mem_rd", mem_if.mem_rd, 0);
        check("abort_mem_addr", mem_if.mem_addr, 0);
        check("abort_buff_addr", sec_if.sd_buff_addr, 0);
        check("abort_busy", busy, 0);
        $display("xfer abort: strobes_before_reset=%0d", strobe_n);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_stays_idle", busy, 0);
        run_vec(9, vecs[0]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
